exc_commit: RTL and testbench
=============================

EXC_COMMIT -- requirements
Module: exc_commit

Interface
REQ-001 SHALL have ports: clk  in  1  single clock, all state updates on rising edge.
REQ-002 SHALL have ports: rst  in  1  asynchronous, active-high reset.
REQ-003 SHALL have ports: exc_flag  in  1  exception/ERET commit request from the exception prioritizer.
REQ-004 SHALL have ports: exc_type  in  5  cause code: 00 Int, 04 AdEL, 05 AdES, 08 Sys, 09 Bp, 0A RI, 0B CpU, 0C Ov, 0D Tr, 1E ERET, 1F none.
REQ-005 SHALL have ports: exc_baddr  in  32  faulting address for AdEL/AdES.
REQ-006 SHALL have ports: pc  in  32  PC of the committing instruction; in_dslot  in  1  the instruction is in a branch delay slot.
REQ-007 SHALL have ports: hw_int  in  6  hardware interrupt lines, level-sensitive.
REQ-008 SHALL have ports: cp0_we  in  1, cp0_waddr  in  5, cp0_wdata  in  32  MTC0 write (sel 0 only).
REQ-009 SHALL have ports: cp0_raddr  in  5, cp0_rdata  out  32  MFC0 read, combinational from current register state.
REQ-010 SHALL have ports: cp0_Status, cp0_Cause, cp0_EPC  out  32 each  live register values for the prioritizer.
REQ-011 SHALL have ports: exc_redirect  out  1  one-cycle flush/redirect pulse; exc_target  out  32  redirect PC; timer_int  out  1  Cause.TI.

Function
REQ-012 SHALL implement BadVAddr(8), Count(9), Compare(11), Status(12), Cause(13), EPC(14); any other address SHALL read 0 and ignore writes.
REQ-013 SHALL treat Status writable bits as IM[15:8], ERL[2], EXL[1], IE[0]; BEV[22] read-only; all other bits read 0.
REQ-014 SHALL treat Cause writable bits as IP[9:8] only; BD[31], TI[30], IP[15:10], ExcCode[6:2] hardware-owned.
REQ-015 SHALL load Cause.IP[15:10] each cycle with {hw_int[5] | TI, hw_int[4:0]}.
REQ-016 SHALL increment Count on every second clock via an internal toggle; an MTC0 to Count SHALL load Count and clear the toggle.
REQ-017 SHALL set TI when Count equals Compare and no Compare write occurs that cycle; an MTC0 to Compare SHALL clear TI.
REQ-018 On exc_flag with exc_type other than 1E/1F: if Status.EXL=0, SHALL write EPC = in_dslot ? pc-4 : pc and Cause.BD = in_dslot; if EXL=1, EPC and BD SHALL be left unchanged.
REQ-019 On such an exception SHALL write Cause.ExcCode = exc_type and set Status.EXL=1.
REQ-020 SHALL write BadVAddr = exc_baddr only for exc_type 04 or 05.
REQ-021 On exc_flag with exc_type 1E (ERET): SHALL clear ERL if ERL=1, otherwise clear EXL; target SHALL be the EPC value before this edge.
REQ-022 Exception target SHALL be 0xBFC00380 when BEV=1, otherwise 0x80000180.
REQ-023 SHALL register the commit: exc_redirect high for exactly the one cycle after the accepting edge, with exc_target valid in that cycle; exc_target SHALL be 0 otherwise.
REQ-024 SHALL ignore exc_flag during a cycle in which exc_redirect is high (the shadow of a flush).
REQ-025 Exception commit and cp0_we in the same cycle: the commit SHALL win and the MTC0 SHALL be discarded entirely.
REQ-026 exc_flag with exc_type 1F, or exc_type not in the REQ-004 list, SHALL change no state and raise no redirect.
REQ-027 An MTC0 and a subsequent MFC0 to the same register SHALL return the written value on the cycle after the write.

Reset
REQ-028 On rst: Status = 0x00400004 (BEV=1, ERL=1); Cause, EPC, BadVAddr, Count, Compare = 0; toggle = 0; exc_redirect = 0; exc_target = 0; timer_int = 0.
REQ-029 Reset asserted mid-commit SHALL immediately drop exc_redirect and discard the pending commit.

Verification
REQ-030 Reset, then MTC0 Status=0x0000FF01 -> cp0_Status reads 0x0040FF01; exception type 0C at pc=0x80001000, in_dslot=0 -> next cycle exc_redirect=1, exc_target=0xBFC00380, EPC=0x80001000, ExcCode=0x0C, EXL=1.
REQ-031 With Status BEV cleared by prior setup (forced to 0) and EXL=0: AdES at pc=0x80002004, in_dslot=1, exc_baddr=0x00000003 -> EPC=0x80002000, BD=1, BadVAddr=0x00000003, target=0x80000180.
REQ-032 Nested: EXL=1, EPC=0x80001000, exception type 08 -> EPC and BD unchanged, ExcCode=0x08, redirect raised.
REQ-033 ERET with ERL=0, EXL=1, EPC=0x80003000 -> EXL=0, exc_target=0x80003000 for one cycle; ERET with ERL=1 -> ERL cleared, EXL unchanged.
REQ-034 MTC0 Compare=5, MTC0 Count=0 -> TI and timer_int rise within 11 cycles, Cause.IP[15]=1; MTC0 Compare=100 -> TI=0 next cycle.
REQ-035 exc_flag and cp0_we (EPC=0x12345678) in the same cycle -> EPC holds exception PC; exc_flag held two cycles -> exactly one redirect pulse.

Source files
------------

// File: rtl/exc_commit.sv
// exc_commit: CP0 register file and exception/ERET commit stage.
//
// Holds BadVAddr, Count, Compare, Status, Cause and EPC. When the exception
// prioritizer presents a recognised exception or ERET, the stage updates CP0
// state on that edge and raises a registered one-cycle redirect carrying the
// new fetch PC.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   exc_flag            commit request (exception or ERET)
//   exc_type[4:0]       cause code of the request (1E = ERET, 1F = none)
//   exc_baddr[31:0]     faulting address for AdEL/AdES
//   pc[31:0], in_dslot  committing instruction PC and delay-slot flag
//   hw_int[5:0]         level-sensitive hardware interrupt lines
//   cp0_we/waddr/wdata  MTC0 write port
//   cp0_raddr/rdata     MFC0 read port (combinational)
//   cp0_Status/Cause/EPC live register values
//   exc_redirect        one-cycle flush/redirect pulse
//   exc_target[31:0]    redirect PC, zero when no redirect
//   timer_int           Cause.TI
module exc_commit (
    input  logic        clk,
    input  logic        rst,
    input  logic        exc_flag,
    input  logic [4:0]  exc_type,
    input  logic [31:0] exc_baddr,
    input  logic [31:0] pc,
    input  logic        in_dslot,
    input  logic [5:0]  hw_int,
    input  logic        cp0_we,
    input  logic [4:0]  cp0_waddr,
    input  logic [31:0] cp0_wdata,
    input  logic [4:0]  cp0_raddr,
    output logic [31:0] cp0_rdata,
    output logic [31:0] cp0_Status,
    output logic [31:0] cp0_Cause,
    output logic [31:0] cp0_EPC,
    output logic        exc_redirect,
    output logic [31:0] exc_target,
    output logic        timer_int
);

    localparam logic [4:0] ADDR_BADVADDR = 5'd8;
    localparam logic [4:0] ADDR_COUNT    = 5'd9;
    localparam logic [4:0] ADDR_COMPARE  = 5'd11;
    localparam logic [4:0] ADDR_STATUS   = 5'd12;
    localparam logic [4:0] ADDR_CAUSE    = 5'd13;
    localparam logic [4:0] ADDR_EPC      = 5'd14;

    localparam logic [4:0] EXC_INT  = 5'h00;
    localparam logic [4:0] EXC_ADEL = 5'h04;
    localparam logic [4:0] EXC_ADES = 5'h05;
    localparam logic [4:0] EXC_SYS  = 5'h08;
    localparam logic [4:0] EXC_BP   = 5'h09;
    localparam logic [4:0] EXC_RI   = 5'h0A;
    localparam logic [4:0] EXC_CPU  = 5'h0B;
    localparam logic [4:0] EXC_OV   = 5'h0C;
    localparam logic [4:0] EXC_TR   = 5'h0D;
    localparam logic [4:0] EXC_ERET = 5'h1E;

    localparam logic [31:0] VEC_BOOT = 32'hBFC0_0380;
    localparam logic [31:0] VEC_NORM = 32'h8000_0180;

    // Status fields
    logic        bev;
    logic [7:0]  status_im;
    logic        status_erl;
    logic        status_exl;
    logic        status_ie;

    // Cause fields
    logic        cause_bd;
    logic        cause_ti;
    logic [5:0]  cause_ip_hw;
    logic [1:0]  cause_ip_sw;
    logic [4:0]  cause_exc_code;

    logic [31:0] epc;
    logic [31:0] badvaddr;
    logic [31:0] count;
    logic [31:0] compare;
    logic        count_tog;

    logic        type_known;
    logic        accept;
    logic        exc_take;
    logic        eret_take;
    logic        mtc0;

    always_comb begin
        type_known = 1'b0;
        case (exc_type)
            EXC_INT, EXC_ADEL, EXC_ADES, EXC_SYS, EXC_BP, EXC_RI,
            EXC_CPU, EXC_OV, EXC_TR, EXC_ERET: type_known = 1'b1;
            default:                           type_known = 1'b0;
        endcase
    end

    // A request arriving while the previous redirect is still out is in the
    // flush shadow and must not commit a second time.
    assign accept    = exc_flag && type_known && !exc_redirect;
    assign exc_take  = accept && (exc_type != EXC_ERET);
    assign eret_take = accept && (exc_type == EXC_ERET);
    // A commit in the same cycle discards the MTC0 completely.
    assign mtc0      = cp0_we && !accept;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bev        <= 1'b1;
            status_im  <= 8'h00;
            status_erl <= 1'b1;
            status_exl <= 1'b0;
            status_ie  <= 1'b0;
        end else if (exc_take) begin
            status_exl <= 1'b1;
        end else if (eret_take) begin
            if (status_erl)
                status_erl <= 1'b0;
            else
                status_exl <= 1'b0;
        end else if (mtc0 && cp0_waddr == ADDR_STATUS) begin
            status_im  <= cp0_wdata[15:8];
            status_erl <= cp0_wdata[2];
            status_exl <= cp0_wdata[1];
            status_ie  <= cp0_wdata[0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cause_bd       <= 1'b0;
            cause_ip_hw    <= 6'h00;
            cause_ip_sw    <= 2'b00;
            cause_exc_code <= 5'h00;
        end else begin
            // IP[15] shares the line with the timer interrupt.
            cause_ip_hw <= {hw_int[5] | cause_ti, hw_int[4:0]};
            if (exc_take) begin
                cause_exc_code <= exc_type;
                if (!status_exl)
                    cause_bd <= in_dslot;
            end else if (mtc0 && cp0_waddr == ADDR_CAUSE) begin
                cause_ip_sw <= cp0_wdata[9:8];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            epc <= 32'h0;
        end else if (exc_take) begin
            // Nested exceptions keep the original return address.
            if (!status_exl)
                epc <= in_dslot ? (pc - 32'd4) : pc;
        end else if (mtc0 && cp0_waddr == ADDR_EPC) begin
            epc <= cp0_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            badvaddr <= 32'h0;
        end else if (exc_take) begin
            if (exc_type == EXC_ADEL || exc_type == EXC_ADES)
                badvaddr <= exc_baddr;
        end else if (mtc0 && cp0_waddr == ADDR_BADVADDR) begin
            badvaddr <= cp0_wdata;
        end
    end

    // Count advances at half the clock rate: the toggle gates every other edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count     <= 32'h0;
            count_tog <= 1'b0;
        end else if (mtc0 && cp0_waddr == ADDR_COUNT) begin
            count     <= cp0_wdata;
            count_tog <= 1'b0;
        end else begin
            count_tog <= ~count_tog;
            if (count_tog)
                count <= count + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            compare  <= 32'h0;
            cause_ti <= 1'b0;
        end else if (mtc0 && cp0_waddr == ADDR_COMPARE) begin
            compare  <= cp0_wdata;
            cause_ti <= 1'b0;
        end else if (count == compare) begin
            cause_ti <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exc_redirect <= 1'b0;
            exc_target   <= 32'h0;
        end else begin
            exc_redirect <= accept;
            if (eret_take)
                exc_target <= epc;
            else if (exc_take)
                exc_target <= bev ? VEC_BOOT : VEC_NORM;
            else
                exc_target <= 32'h0;
        end
    end

    assign cp0_Status = {9'b0, bev, 6'b0, status_im, 5'b0,
                         status_erl, status_exl, status_ie};
    assign cp0_Cause  = {cause_bd, cause_ti, 14'b0, cause_ip_hw, cause_ip_sw,
                         1'b0, cause_exc_code, 2'b00};
    assign cp0_EPC    = epc;
    assign timer_int  = cause_ti;

    always_comb begin
        cp0_rdata = 32'h0;
        case (cp0_raddr)
            ADDR_BADVADDR: cp0_rdata = badvaddr;
            ADDR_COUNT:    cp0_rdata = count;
            ADDR_COMPARE:  cp0_rdata = compare;
            ADDR_STATUS:   cp0_rdata = cp0_Status;
            ADDR_CAUSE:    cp0_rdata = cp0_Cause;
            ADDR_EPC:      cp0_rdata = epc;
            default:       cp0_rdata = 32'h0;
        endcase
    end

endmodule

// File: tb/tb_exc_commit.sv
module tb_exc_commit;

    logic        clk;
    logic        rst;
    logic        exc_flag;
    logic [4:0]  exc_type;
    logic [31:0] exc_baddr;
    logic [31:0] pc;
    logic        in_dslot;
    logic [5:0]  hw_int;
    logic        cp0_we;
    logic [4:0]  cp0_waddr;
    logic [31:0] cp0_wdata;
    logic [4:0]  cp0_raddr;
    logic [31:0] cp0_rdata;
    logic [31:0] cp0_Status;
    logic [31:0] cp0_Cause;
    logic [31:0] cp0_EPC;
    logic        exc_redirect;
    logic [31:0] exc_target;
    logic        timer_int;

    int checks = 0;
    int errors = 0;

    // Expected redirect targets, pushed when a commit is driven.
    logic [31:0] exp_q[$];

    exc_commit dut (
        .clk          (clk),
        .rst          (rst),
        .exc_flag     (exc_flag),
        .exc_type     (exc_type),
        .exc_baddr    (exc_baddr),
        .pc           (pc),
        .in_dslot     (in_dslot),
        .hw_int       (hw_int),
        .cp0_we       (cp0_we),
        .cp0_waddr    (cp0_waddr),
        .cp0_wdata    (cp0_wdata),
        .cp0_raddr    (cp0_raddr),
        .cp0_rdata    (cp0_rdata),
        .cp0_Status   (cp0_Status),
        .cp0_Cause    (cp0_Cause),
        .cp0_EPC      (cp0_EPC),
        .exc_redirect (exc_redirect),
        .exc_target   (exc_target),
        .timer_int    (timer_int)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard side: every redirect pulse must match the next queued target.
    always @(negedge clk) begin
        if (exc_redirect) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL redirect_unexpected: got target %h, expected no redirect", exc_target);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (exc_target !== e) begin
                    errors++;
                    $display("FAIL redirect_target: got %h, expected %h", exc_target, e);
                end
            end
        end else begin
            checks++;
            if (exc_target !== 32'h0) begin
                errors++;
                $display("FAIL idle_target: got %h, expected 00000000", exc_target);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        cp0_we    = 1'b1;
        cp0_waddr = a;
        cp0_wdata = d;
        tick();
        cp0_we    = 1'b0;
    endtask

    task automatic rd(input logic [4:0] a, output logic [31:0] d);
        cp0_raddr = a;
        #1;
        d = cp0_rdata;
    endtask

    task automatic drive_exc(input logic [4:0] t, input logic [31:0] p,
                             input logic ds, input logic [31:0] ba,
                             input logic push, input logic [31:0] tgt);
        exc_flag  = 1'b1;
        exc_type  = t;
        pc        = p;
        in_dslot  = ds;
        exc_baddr = ba;
        if (push) exp_q.push_back(tgt);
        tick();
        exc_flag  = 1'b0;
        exc_type  = 5'h1F;
    endtask

    task automatic sb_drain(input string name);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_sb_pending: got %0d pending redirects, expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        logic [31:0] v;
        rst = 1'b1;
        tick();
        tick();
        checks++; if (cp0_Status !== 32'h0040_0004) begin errors++; $display("FAIL reset_status: got %h, expected 00400004", cp0_Status); end
        checks++; if (cp0_Cause !== 32'h0) begin errors++; $display("FAIL reset_cause: got %h, expected 0", cp0_Cause); end
        checks++; if (cp0_EPC !== 32'h0) begin errors++; $display("FAIL reset_epc: got %h, expected 0", cp0_EPC); end
        checks++; if (exc_redirect !== 1'b0 || exc_target !== 32'h0) begin errors++; $display("FAIL reset_redirect: got %b/%h, expected 0/0", exc_redirect, exc_target); end
        checks++; if (timer_int !== 1'b0) begin errors++; $display("FAIL reset_ti: got %b, expected 0", timer_int); end
        rd(5'd8, v);  checks++; if (v !== 32'h0) begin errors++; $display("FAIL reset_badvaddr: got %h, expected 0", v); end
        rd(5'd9, v);  checks++; if (v !== 32'h0) begin errors++; $display("FAIL reset_count: got %h, expected 0", v); end
        rd(5'd11, v); checks++; if (v !== 32'h0) begin errors++; $display("FAIL reset_compare: got %h, expected 0", v); end
        @(posedge clk); #1;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic_exc();
        logic [31:0] v;
        mtc0(5'd12, 32'h0000_FF01);
        checks++; if (cp0_Status !== 32'h0040_FF01) begin errors++; $display("FAIL basic_status_write: got %h, expected 0040ff01", cp0_Status); end
        rd(5'd12, v); checks++; if (v !== 32'h0040_FF01) begin errors++; $display("FAIL basic_mfc0_status: got %h, expected 0040ff01", v); end
        mtc0(5'd5, 32'hFFFF_FFFF);
        rd(5'd5, v); checks++; if (v !== 32'h0) begin errors++; $display("FAIL basic_unimpl_reg: got %h, expected 0", v); end
        drive_exc(5'h0C, 32'h8000_1000, 1'b0, 32'h0, 1'b1, 32'hBFC0_0380);
        checks++; if (exc_redirect !== 1'b1) begin errors++; $display("FAIL basic_redirect: got %b, expected 1", exc_redirect); end
        checks++; if (cp0_EPC !== 32'h8000_1000) begin errors++; $display("FAIL basic_epc: got %h, expected 80001000", cp0_EPC); end
        checks++; if (cp0_Cause[6:2] !== 5'h0C) begin errors++; $display("FAIL basic_exccode: got %h, expected 0c", cp0_Cause[6:2]); end
        checks++; if (cp0_Status[1] !== 1'b1 || cp0_Cause[31] !== 1'b0) begin errors++; $display("FAIL basic_exl_bd: got %b/%b, expected 1/0", cp0_Status[1], cp0_Cause[31]); end
        tick();
        checks++; if (exc_redirect !== 1'b0) begin errors++; $display("FAIL basic_pulse_width: got %b, expected 0", exc_redirect); end
        sb_drain("basic");
    endtask

    task automatic test_nested();
        drive_exc(5'h08, 32'h9000_0000, 1'b1, 32'h0, 1'b1, 32'hBFC0_0380);
        checks++; if (cp0_EPC !== 32'h8000_1000) begin errors++; $display("FAIL nested_epc: got %h, expected 80001000", cp0_EPC); end
        checks++; if (cp0_Cause[31] !== 1'b0) begin errors++; $display("FAIL nested_bd: got %b, expected 0", cp0_Cause[31]); end
        checks++; if (cp0_Cause[6:2] !== 5'h08) begin errors++; $display("FAIL nested_exccode: got %h, expected 08", cp0_Cause[6:2]); end
        tick();
        sb_drain("nested");
    endtask

    task automatic test_eret();
        mtc0(5'd14, 32'h8000_3000);
        checks++; if (cp0_EPC !== 32'h8000_3000) begin errors++; $display("FAIL eret_epc_write: got %h, expected 80003000", cp0_EPC); end
        drive_exc(5'h1E, 32'h0, 1'b0, 32'h0, 1'b1, 32'h8000_3000);
        checks++; if (cp0_Status !== 32'h0040_FF01) begin errors++; $display("FAIL eret_exl_clear: got %h, expected 0040ff01", cp0_Status); end
        tick();
        mtc0(5'd12, 32'h0000_FF07);
        drive_exc(5'h1E, 32'h0, 1'b0, 32'h0, 1'b1, 32'h8000_3000);
        checks++; if (cp0_Status !== 32'h0040_FF03) begin errors++; $display("FAIL eret_erl_clear: got %h, expected 0040ff03", cp0_Status); end
        tick();
        sb_drain("eret");
    endtask

    task automatic test_invalid();
        drive_exc(5'h03, 32'h8000_7000, 1'b1, 32'h1234, 1'b0, 32'h0);
        tick();
        drive_exc(5'h1F, 32'h8000_7004, 1'b1, 32'h1234, 1'b0, 32'h0);
        tick();
        checks++; if (cp0_Status !== 32'h0040_FF03) begin errors++; $display("FAIL invalid_status: got %h, expected 0040ff03", cp0_Status); end
        checks++; if (cp0_EPC !== 32'h8000_3000) begin errors++; $display("FAIL invalid_epc: got %h, expected 80003000", cp0_EPC); end
        checks++; if (cp0_Cause[6:2] !== 5'h08 || cp0_Cause[31] !== 1'b0) begin errors++; $display("FAIL invalid_cause: got %h, expected exccode 08 bd 0", cp0_Cause); end
        sb_drain("invalid");
    endtask

    task automatic test_timer();
        logic [31:0] v;
        int n;
        mtc0(5'd9, 32'h0);
        mtc0(5'd11, 32'd5);
        mtc0(5'd9, 32'h0);
        checks++; if (timer_int !== 1'b0) begin errors++; $display("FAIL timer_clear: got %b, expected 0", timer_int); end
        n = 0;
        while (timer_int !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        checks++; if (timer_int !== 1'b1 || n < 2 || n > 11) begin errors++; $display("FAIL timer_rise: got ti=%b after %0d cycles, expected ti=1 within 11", timer_int, n); end
        rd(5'd9, v); checks++; if (v !== 32'd5) begin errors++; $display("FAIL timer_count: got %0d, expected 5", v); end
        tick();
        checks++; if (cp0_Cause[15] !== 1'b1 || cp0_Cause[30] !== 1'b1) begin errors++; $display("FAIL timer_ip7: got %h, expected bits 30 and 15 set", cp0_Cause); end
        mtc0(5'd11, 32'd100);
        checks++; if (timer_int !== 1'b0) begin errors++; $display("FAIL timer_compare_clear: got %b, expected 0", timer_int); end
        rd(5'd11, v); checks++; if (v !== 32'd100) begin errors++; $display("FAIL timer_compare_read: got %0d, expected 100", v); end
        tick();
        hw_int = 6'b10_0101;
        tick();
        checks++; if (cp0_Cause[15:10] !== 6'b10_0101) begin errors++; $display("FAIL hwint_ip: got %b, expected 100101", cp0_Cause[15:10]); end
        hw_int = 6'b00_0000;
        mtc0(5'd13, 32'hFFFF_FFFF);
        checks++; if (cp0_Cause[15:8] !== 8'b0000_0011) begin errors++; $display("FAIL cause_ip_write: got %b, expected 00000011", cp0_Cause[15:8]); end
        checks++; if (cp0_Cause[6:2] !== 5'h08 || cp0_Cause[31] !== 1'b0) begin errors++; $display("FAIL cause_ro_fields: got %h, expected exccode 08 bd 0", cp0_Cause); end
        sb_drain("timer");
    endtask

    task automatic test_collision();
        mtc0(5'd12, 32'h0000_FF01);
        cp0_we    = 1'b1;
        cp0_waddr = 5'd14;
        cp0_wdata = 32'h1234_5678;
        drive_exc(5'h0D, 32'h8000_4000, 1'b0, 32'h0, 1'b1, 32'hBFC0_0380);
        cp0_we    = 1'b0;
        checks++; if (cp0_EPC !== 32'h8000_4000) begin errors++; $display("FAIL collision_epc: got %h, expected 80004000", cp0_EPC); end
        tick();
        checks++; if (cp0_EPC !== 32'h8000_4000 || cp0_Status[1] !== 1'b1) begin errors++; $display("FAIL collision_hold: got epc %h exl %b, expected 80004000/1", cp0_EPC, cp0_Status[1]); end
        sb_drain("collision");
    endtask

    task automatic test_back_to_back();
        exc_flag = 1'b1;
        exc_type = 5'h09;
        pc       = 32'h8000_5000;
        in_dslot = 1'b0;
        exp_q.push_back(32'hBFC0_0380);
        tick();
        checks++; if (exc_redirect !== 1'b1) begin errors++; $display("FAIL b2b_first: got %b, expected 1", exc_redirect); end
        tick();
        checks++; if (exc_redirect !== 1'b0) begin errors++; $display("FAIL b2b_shadow: got %b, expected 0", exc_redirect); end
        exc_flag = 1'b0;
        exc_type = 5'h1F;
        tick();
        checks++; if (cp0_Cause[6:2] !== 5'h09 || cp0_EPC !== 32'h8000_4000) begin errors++; $display("FAIL b2b_state: got exccode %h epc %h, expected 09/80004000", cp0_Cause[6:2], cp0_EPC); end
        sb_drain("b2b");
    endtask

    task automatic test_bev0();
        logic [31:0] v;
        force dut.bev = 1'b0;
        mtc0(5'd12, 32'h0);
        checks++; if (cp0_Status !== 32'h0) begin errors++; $display("FAIL bev0_status: got %h, expected 0", cp0_Status); end
        drive_exc(5'h05, 32'h8000_2004, 1'b1, 32'h0000_0003, 1'b1, 32'h8000_0180);
        checks++; if (cp0_EPC !== 32'h8000_2000) begin errors++; $display("FAIL bev0_epc: got %h, expected 80002000", cp0_EPC); end
        checks++; if (cp0_Cause[31] !== 1'b1 || cp0_Cause[6:2] !== 5'h05) begin errors++; $display("FAIL bev0_cause: got %h, expected bd 1 exccode 05", cp0_Cause); end
        rd(5'd8, v); checks++; if (v !== 32'h3) begin errors++; $display("FAIL bev0_badvaddr: got %h, expected 3", v); end
        tick();
        drive_exc(5'h0C, 32'h8000_6000, 1'b0, 32'hDEAD_BEEF, 1'b1, 32'h8000_0180);
        rd(5'd8, v); checks++; if (v !== 32'h3) begin errors++; $display("FAIL badvaddr_hold: got %h, expected 3", v); end
        tick();
        release dut.bev;
        sb_drain("bev0");
    endtask

    task automatic test_reset_mid();
        drive_exc(5'h0C, 32'h8000_8000, 1'b0, 32'h0, 1'b0, 32'h0);
        checks++; if (exc_redirect !== 1'b1) begin errors++; $display("FAIL rstmid_pre: got %b, expected 1", exc_redirect); end
        rst = 1'b1;
        #1;
        checks++; if (exc_redirect !== 1'b0 || exc_target !== 32'h0) begin errors++; $display("FAIL rstmid_drop: got %b/%h, expected 0/0", exc_redirect, exc_target); end
        checks++; if (cp0_Status !== 32'h0040_0004 || cp0_EPC !== 32'h0) begin errors++; $display("FAIL rstmid_state: got status %h epc %h, expected 00400004/0", cp0_Status, cp0_EPC); end
        tick();
        tick();
        rst = 1'b0;
        tick();
        sb_drain("rstmid");
    endtask

    initial begin
        rst       = 1'b1;
        exc_flag  = 1'b0;
        exc_type  = 5'h1F;
        exc_baddr = 32'h0;
        pc        = 32'h0;
        in_dslot  = 1'b0;
        hw_int    = 6'h00;
        cp0_we    = 1'b0;
        cp0_waddr = 5'd0;
        cp0_wdata = 32'h0;
        cp0_raddr = 5'd0;
        test_reset();
        test_basic_exc();
        test_nested();
        test_eret();
        test_invalid();
        test_timer();
        test_collision();
        test_back_to_back();
        test_bev0();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
